// File: rtl/fnd_scan_drv_if.sv
// Digit/decimal-point load bus from the formatter stage, plus the FND pin outputs.
interface fnd_scan_drv_if;
  logic [23:0] i_digits;
  logic [5:0]  i_dp;
  logic        i_load;
  logic        i_lzb;
  logic [5:0]  i_blink;
  logic        o_pending;
  logic [5:0]  o_seg_enb;
  logic [6:0]  o_seg;
  logic        o_seg_dp;

  modport master (
    output i_digits, i_dp, i_load, i_lzb, i_blink,
    input  o_pending, o_seg_enb, o_seg, o_seg_dp
  );

  modport slave (
    input  i_digits, i_dp, i_load, i_lzb, i_blink,
    output o_pending, o_seg_enb, o_seg, o_seg_dp
  );
endinterface

// File: rtl/fnd_scan_drv.sv
// 6-digit multiplexed 7-segment scan driver with double-buffered frame data.
// Optional per-digit blinking is built only when FND_BLINK_EN is defined.
module fnd_scan_drv #(
  parameter int SCAN_DIV     = 50000,
  parameter int DIV_W        = 16,
  parameter int BLINK_FRAMES = 100
) (
  input  logic           clk,
  input  logic           rst,
  fnd_scan_drv_if.slave  bus
);

  localparam int DIGITS = 6;

  typedef struct packed {
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0][3:0] dig;
  } frame_t;

  logic [DIV_W-1:0]  presc;
  logic [2:0]        idx, nidx;
  logic              scan_on;
  logic              tick, frame_end;
  logic              pending;
  frame_t            in_frame, staging, shadow, shadow_nxt;
  logic [DIGITS-1:0] blank;
  logic              dark;
  logic [3:0]        cur_dig;
  logic              cur_dp;
  logic [DIGITS-1:0] seg_enb;
  logic [6:0]        seg;
  logic              seg_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] p;
    p = 7'b0000000;
    case (h)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      4'hF: p = 7'b1000111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  assign tick      = (presc == DIV_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == 3'd5);
  // The very first tick after reset lights digit 0 rather than stepping past it.
  assign nidx      = (!scan_on || idx == 3'd5) ? 3'd0 : idx + 3'd1;
  assign in_frame  = {bus.i_dp, bus.i_digits};

  // Slot 0 of a new frame decodes from the buffer it is about to latch, so a
  // frame never pairs an old digit 0 with new digits 1..5.
  assign shadow_nxt = frame_end ? (bus.i_load ? in_frame : staging) : shadow;

  assign blank[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_lzb
    assign blank[k] = bus.i_lzb && ~|shadow_nxt.dig[DIGITS-1:k];
  end

`ifdef FND_BLINK_EN
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FCW-1:0] fcnt;
  logic           phase, phase_nxt, fwrap;

  assign fwrap     = (fcnt == FCW'(BLINK_FRAMES - 1));
  assign phase_nxt = (frame_end && fwrap) ? ~phase : phase;
  assign dark      = phase_nxt && bus.i_blink[nidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_end) begin
      fcnt  <= fwrap ? '0 : fcnt + 1'b1;
      phase <= phase_nxt;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^bus.i_blink;
  assign dark = 1'b0;
`endif

  assign cur_dig = shadow_nxt.dig[nidx];
  assign cur_dp  = shadow_nxt.dp[nidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      idx     <= 3'd0;
      scan_on <= 1'b0;
    end else if (tick) begin
      presc   <= '0;
      idx     <= nidx;
      scan_on <= 1'b1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (bus.i_load) staging <= in_frame;
      shadow <= shadow_nxt;
      if (frame_end)       pending <= 1'b0;
      else if (bus.i_load) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_enb <= '1;
      seg     <= '0;
      seg_dp  <= 1'b0;
    end else if (tick) begin
      seg_enb <= ~(6'b1 << nidx);
      seg     <= (blank[nidx] || dark) ? 7'b0 : seg_decode(cur_dig);
      seg_dp  <= dark ? 1'b0 : cur_dp;
    end
  end

  assign bus.o_pending = pending;
  assign bus.o_seg_enb = seg_enb;
  assign bus.o_seg     = seg;
  assign bus.o_seg_dp  = seg_dp;

endmodule

// File: tb/tb_fnd_scan_drv.sv
// Bench for fnd_scan_drv: slot/frame model from elapsed clocks plus directed literal checks.
module tb_fnd_scan_drv;
  localparam int SD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fnd_scan_drv_if bus();

  fnd_scan_drv #(.SCAN_DIV(SD), .DIV_W(16), .BLINK_FRAMES(BF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Model: the n-th digit slot since reset starts after edge n*SD and shows
  // digit (n-1)%6 of frame (n-1)/6; a frame shows the latest load as of its start.
  int          e = 0;
  int          m, d;
  logic [29:0] latest = '0, shadow_m = '0;
  logic [23:0] val;
  bit          pend_m = 0, started = 0, blank, dark;
  logic [5:0]  enb_m = 6'h3f;
  logic [6:0]  seg_m = '0;
  logic        dp_m = 1'b0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      e = 0; latest = '0; shadow_m = '0; pend_m = 0;
      enb_m = 6'h3f; seg_m = '0; dp_m = 1'b0;
    end else begin
      e++;
      if (bus.i_load) begin
        latest = {bus.i_dp, bus.i_digits};
        pend_m = 1;
      end
      if (e % SD == 0) begin
        m = e / SD;
        d = (m - 1) % 6;
        if (m > 1 && d == 0) begin
          shadow_m = latest;
          pend_m   = 0;
        end
        val   = shadow_m[23:0];
        blank = bus.i_lzb && d != 0 && ((val >> (4 * d)) == 0);
`ifdef FND_BLINK_EN
        dark  = ((((m - 1) / 6) / BF) % 2 == 1) && bus.i_blink[d];
`else
        dark  = 0;
`endif
        enb_m = ~(6'(1) << d);
        seg_m = (blank || dark) ? 7'b0 : seg_tab[4'((val >> (4 * d)) & 24'hF)];
        dp_m  = dark ? 1'b0 : shadow_m[24 + d];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("seg_enb", 32'(bus.o_seg_enb), 32'(enb_m));
      chk("seg", 32'(bus.o_seg), 32'(seg_m));
      chk("seg_dp", 32'(bus.o_seg_dp), 32'(dp_m));
      chk("pending", 32'(bus.o_pending), 32'(pend_m));
    end
  end

  // Returns at a negedge on which digit k has just become the active slot.
  task automatic wait_digit(input int k);
    int n;
    logic [5:0] tgt;
    n = 0;
    tgt = ~(6'(1) << k);
    while (bus.o_seg_enb == tgt && n < 200) begin @(negedge clk); n++; end
    while (bus.o_seg_enb != tgt && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_digit%0d: timeout, enables %b expected %b", k, bus.o_seg_enb, tgt);
    end
  endtask

  task automatic pulse_load(input logic [23:0] dig, input logic [5:0] dp);
    bus.i_digits = dig;
    bus.i_dp     = dp;
    bus.i_load   = 1'b1;
    @(negedge clk);
    bus.i_load   = 1'b0;
  endtask

  logic [6:0] exp3 [6];
  bit   [7:0] lit;

  initial begin
    bus.i_digits = '0; bus.i_dp = '0; bus.i_load = 1'b0;
    bus.i_lzb = 1'b0; bus.i_blink = '0;
    repeat (3) @(negedge clk);
    chk("reset_enb", 32'(bus.o_seg_enb), 32'h3f);
    chk("reset_seg", 32'(bus.o_seg), 32'h0);
    chk("reset_pending", 32'(bus.o_pending), 32'h0);
    rst = 1'b0;

    // Edges 1..3 after release hold reset values; edge 4 is the first tick.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_enb", 32'(bus.o_seg_enb), 32'h3f);
    end
    @(negedge clk);
    chk("first_tick_enb", 32'(bus.o_seg_enb), 32'(6'b111110));

    // Basic display with a decimal point on digit 2.
    pulse_load(24'h123456, 6'b000100);
    repeat (48) @(negedge clk);
    wait_digit(0);
    chk("t2_d0_seg", 32'(bus.o_seg), 32'(7'b1011111));
    chk("t2_d0_dp", 32'(bus.o_seg_dp), 32'h0);
    wait_digit(2);
    chk("t2_d2_seg", 32'(bus.o_seg), 32'(7'b0110011));
    chk("t2_d2_dp", 32'(bus.o_seg_dp), 32'h1);
    wait_digit(5);
    chk("t2_d5_enb", 32'(bus.o_seg_enb), 32'(6'b011111));

    // Leading-zero blanking on and off.
    bus.i_lzb = 1'b1;
    pulse_load(24'h000070, 6'b000000);
    repeat (48) @(negedge clk);
    exp3 = '{7'b1111110, 7'b1110000, 7'b0, 7'b0, 7'b0, 7'b0};
    for (int k = 0; k < 6; k++) begin
      wait_digit(k);
      chk($sformatf("lzb_on_d%0d", k), 32'(bus.o_seg), 32'(exp3[k]));
    end
    bus.i_lzb = 1'b0;
    repeat (24) @(negedge clk);
    exp3 = '{7'b1111110, 7'b1110000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
    for (int k = 0; k < 6; k++) begin
      wait_digit(k);
      chk($sformatf("lzb_off_d%0d", k), 32'(bus.o_seg), 32'(exp3[k]));
    end

    // Two loads mid-frame: old frame finishes, then the last load shows.
    wait_digit(2);
    bus.i_digits = 24'hAAAAAA; bus.i_dp = '0; bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_digits = 24'hBBBBBB;
    @(negedge clk);
    bus.i_load = 1'b0;
    chk("t4_pending", 32'(bus.o_pending), 32'h1);
    wait_digit(5);
    chk("t4_old_d5", 32'(bus.o_seg), 32'(7'b1111110));
    chk("t4_pending_d5", 32'(bus.o_pending), 32'h1);
    wait_digit(0);
    chk("t4_new_d0", 32'(bus.o_seg), 32'(7'b0011111));
    chk("t4_pending_clr", 32'(bus.o_pending), 32'h0);
    wait_digit(4);
    chk("t4_new_d4", 32'(bus.o_seg), 32'(7'b0011111));

    // Reset mid-scan with a load pending.
    wait_digit(3);
    pulse_load(24'h999999, 6'b111111);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_enb", 32'(bus.o_seg_enb), 32'h3f);
    chk("t5_pending", 32'(bus.o_pending), 32'h0);
    chk("t5_seg", 32'(bus.o_seg), 32'h0);
    rst = 1'b0;
    bus.i_blink = 6'b000001;

    // Blink on digit 0 across eight frames after the reset.
    for (int f = 0; f < 8; f++) begin
      wait_digit(0);
      lit[f] = (bus.o_seg != 7'b0);
      if (f == 0) begin
        chk("t5_cleared_d0", 32'(bus.o_seg), 32'(7'b1111110));
        pulse_load(24'h000008, 6'b000000);
      end
      if (f == 1) chk("t6_d0_eight", 32'(bus.o_seg), 32'(7'b1111111));
    end
`ifdef FND_BLINK_EN
    chk("blink_pattern", 32'(lit), 32'(8'b00110011));
`else
    chk("blink_pattern", 32'(lit), 32'(8'hFF));
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
